// File: rtl/usb_rx_destuff.sv
// USB full-speed receive bit stage: NRZI decode, bit destuffing and LSB-first byte assembly.
// Optional stuffing-violation detection is built when USB_RX_STUFF_ERR_EN is defined.
module usb_rx_destuff #(
  parameter int unsigned STUFF_BITS_N = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_line,
  input  logic       rx_strobe,
  input  logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_stuff_err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ONES_W = $clog2(STUFF_BITS_N + 1);

  typedef logic [BYTE_W-1:0] bus8_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1
`ifdef USB_RX_STUFF_ERR_EN
    , ST_ERR = 2'd2
`endif
  } state_e;

  state_e            state_q, state_d;
  logic              prev_q, prev_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  bus8_t             sr_q, sr_d;
  bus8_t             data_q, data_d;
  logic              valid_q, valid_d;

  logic in_err_c;
  logic take_c;
  logic dec_c;
  logic stuff_c;
  logic viol_c;

`ifdef USB_RX_STUFF_ERR_EN
  logic err_q, err_d;
  assign in_err_c = (state_q == ST_ERR);
`else
  assign in_err_c = 1'b0;
`endif

  // A strobe is taken while active, or in the cycle rx_active falls so a completing byte still emits.
  assign take_c  = rx_strobe && !in_err_c && (rx_active || (state_q == ST_RECV));
  assign dec_c   = (rx_line == prev_q);
  assign stuff_c = (ones_q == ONES_W'(STUFF_BITS_N));

`ifdef USB_RX_STUFF_ERR_EN
  assign viol_c = take_c && rx_active && stuff_c && dec_c;
`else
  assign viol_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rx_active) state_d = ST_RECV;
      ST_RECV: begin
`ifdef USB_RX_STUFF_ERR_EN
        if (viol_c) state_d = ST_ERR;
`endif
      end
      default: ;
    endcase
    if (!rx_active) state_d = ST_IDLE;
  end

  // Datapath and output next-values
  always_comb begin
    prev_d  = prev_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
    err_d   = viol_c;
`endif
    if (take_c) begin
      prev_d = rx_line;
      if (stuff_c) begin
        ones_d = '0;
      end else begin
        sr_d   = {dec_c, sr_q[BYTE_W-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        ones_d = dec_c ? ones_q + ONES_W'(1) : '0;
        if (cnt_q == CNT_W'(BYTE_W - 1)) begin
          data_d  = {dec_c, sr_q[BYTE_W-1:1]};
          valid_d = 1'b1;
        end
      end
    end
    if (!rx_active) begin
      prev_d = 1'b1;
      ones_d = '0;
      cnt_d  = '0;
      sr_d   = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b1;
      ones_q  <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      prev_q  <= prev_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef USB_RX_STUFF_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
`ifdef USB_RX_STUFF_ERR_EN
  assign rx_stuff_err  = err_q;
`else
  assign rx_stuff_err  = 1'b0;
`endif

endmodule
